multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths and encodings are fixed by this document.
REQ-002 clk_i  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 Opcode  input  6  instruction opcode from the instruction register; sampled only in DECODE.
REQ-005 mem_ready  input  1  memory handshake; high means the current memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes and selects.
REQ-007 PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-008 ALUSrcB  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
REQ-009 ALU_OP  output  2  feeds the ALU control stage: 00 add, 01 subtract, 10 decode by Funct.
REQ-010 Illegal  output  1  high during the DECODE cycle when Opcode is unsupported.
REQ-011 State  output  4  current state code, for debug and verification.

Function
REQ-012 The block SHALL be a Moore FSM with one 4-bit state register; all outputs SHALL decode from State, except the mem_ready-qualified strobes in REQ-015 and Illegal.
REQ-013 State codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQ 8, JUMP 9, ADDIEX 10, ADDIWB 11.
REQ-014 In every state, any output not listed for that state SHALL be 0.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_OP=00, PCSource=00, IRWrite=PCWrite=mem_ready; go to DECODE if mem_ready, else stay in FETCH.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_OP=00; next state by Opcode: 000000->RTEX, 100011 or 101011->MEMADR, 000100->BEQ, 000010->JUMP, 001000->ADDIEX, any other->FETCH with Illegal=1.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_OP=00; go to MEMRD if the Opcode latched in DECODE was 100011, else MEMWR.
REQ-018 The block SHALL latch Opcode into an internal register on leaving DECODE, so that later Opcode changes do not affect MEMADR.
REQ-019 MEMRD: MemRead=1, IorD=1; go to MEMWB on mem_ready, else hold.
REQ-020 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; go to FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; go to FETCH on mem_ready, else hold with MemWrite still high.
REQ-022 RTEX: ALUSrcA=1, ALUSrcB=00, ALU_OP=10; go to RTWB.
REQ-023 RTWB: RegDst=1, MemtoReg=0, RegWrite=1; go to FETCH.
REQ-024 BEQ: ALUSrcA=1, ALUSrcB=00, ALU_OP=01, PCWriteCond=1, PCSource=01; go to FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; go to FETCH.
REQ-026 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_OP=00; go to ADDIWB.
REQ-027 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; go to FETCH.
REQ-028 Unused codes 12-15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-029 Instruction latency with mem_ready held high SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles; each wait cycle adds exactly one cycle.
REQ-030 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-031 When rst_i is high at a rising edge, State SHALL become FETCH and the latched opcode SHALL become 000000, whatever the current state or inputs.
REQ-032 Reset SHALL take priority over every transition, including a mem_ready completion in the same cycle; writes already asserted in that cycle are not masked.
REQ-033 After reset, outputs SHALL equal the FETCH decode, with IRWrite=PCWrite=0 until mem_ready=1.

Verification
REQ-034 Reset: assert rst_i for 2 edges, mem_ready=0 -> State=0, MemRead=1, ALUSrcB=01, IRWrite=0, PCWrite=0.
REQ-035 R-type: mem_ready=1, Opcode=000000 -> State sequence 0,1,6,7,0; ALU_OP=10 in state 6; RegWrite=1 and RegDst=1 in state 7.
REQ-036 lw with waits: Opcode=100011, mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; MemtoReg=1 in state 4.
REQ-037 beq/j: Opcode=000100 -> states 0,1,8 with ALU_OP=01, PCWriteCond=1, PCSource=01; Opcode=000010 -> states 0,1,9 with PCWrite=1, PCSource=10.
REQ-038 Illegal: Opcode=111111 -> Illegal=1 in DECODE only, next State=0, and RegWrite/MemWrite never assert.
REQ-039 Mid-operation reset: rst_i=1 while State=5 and mem_ready=0 -> State=0 on the next edge and MemWrite=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-style main controller: a Moore FSM that sequences fetch,
// decode, memory, R-type, branch, jump and addi steps over several cycles.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_OP,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t          state_q, state_n;
  logic [OP_W-1:0] op_q;

  // State register and opcode latch; the opcode is captured while leaving DECODE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_DECODE) op_q <= Opcode;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_n     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALU_OP      = 2'b00;
    Illegal     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_n = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (Opcode)
          OP_RTYPE:      state_n = S_RTEX;
          OP_LW, OP_SW:  state_n = S_MEMADR;
          OP_BEQ:        state_n = S_BEQ;
          OP_J:          state_n = S_JUMP;
          OP_ADDI:       state_n = S_ADDIEX;
          default: begin
            Illegal = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_n = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_n  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        ALUSrcA = 1'b1;
        ALU_OP  = 2'b10;
        state_n = S_RTWB;
      end
      S_RTWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALU_OP      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
  end

  assign State = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instruction sequences plus hand-written
// reset corner cases, checked cycle by cycle through an expected-output queue.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, Illegal;
  logic [1:0] PCSource, ALUSrcB, ALU_OP;
  logic [3:0] State;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALU_OP(ALU_OP), .Illegal(Illegal), .State(State)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] pcsrc, srcb, aluop;
    logic       ill;
    logic [3:0] st;
  } out_t;

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic [0:9][3:0]  seq;
    int               len;
    logic [3:0]       wait_st;
    int               waits;
  } vec_t;

  out_t sb[$];
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;

  // Expected outputs for a given state, straight from the state table
  function automatic out_t model(input logic [3:0] st, input logic mr, input logic [5:0] op);
    out_t o;
    o = '0;
    o.st = st;
    case (st)
      4'd0:  begin o.mrd = 1'b1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      4'd1:  begin
        o.srcb = 2'b11;
        o.ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      end
      4'd2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd3:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      4'd4:  begin o.m2r = 1'b1; o.rw = 1'b1; end
      4'd5:  begin o.mwr = 1'b1; o.iord = 1'b1; end
      4'd6:  begin o.srca = 1'b1; o.aluop = 2'b10; end
      4'd7:  begin o.rdst = 1'b1; o.rw = 1'b1; end
      4'd8:  begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; end
      4'd9:  begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
      4'd10: begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd11: begin o.rw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic vec_t mk(input string n, input logic [5:0] op,
                              input logic [0:9][3:0] seq, input int len,
                              input logic [3:0] wst, input int w);
    vec_t v;
    v.name = n; v.op = op; v.seq = seq; v.len = len; v.wait_st = wst; v.waits = w;
    return v;
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling edge
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input string tag);
    out_t e, a;
    rst_i = r; Opcode = op; mem_ready = mr;
    sb.push_back(model(st, mr, op));
    @(negedge clk_i);
    e = sb.pop_front();
    a = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
          ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALU_OP, Illegal, State};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               tag, a.st, a, e.st, e);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0] = mk("rtype",     6'b000000, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 4, 4'hF, 0);
    vecs[1] = mk("lw_wait",   6'b100011, {4'd0,4'd1,4'd2,4'd3,4'd3,4'd3,4'd4,4'd0,4'd0,4'd0}, 7, 4'd3, 2);
    vecs[2] = mk("sw",        6'b101011, {4'd0,4'd1,4'd2,4'd5,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 4, 4'hF, 0);
    vecs[3] = mk("sw_wait",   6'b101011, {4'd0,4'd1,4'd2,4'd5,4'd5,4'd0,4'd0,4'd0,4'd0,4'd0}, 5, 4'd5, 1);
    vecs[4] = mk("beq",       6'b000100, {4'd0,4'd1,4'd8,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 3, 4'hF, 0);
    vecs[5] = mk("jump",      6'b000010, {4'd0,4'd1,4'd9,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 3, 4'hF, 0);
    vecs[6] = mk("addi",      6'b001000, {4'd0,4'd1,4'd10,4'd11,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 4, 4'hF, 0);
    vecs[7] = mk("illegal3f", 6'b111111, {4'd0,4'd1,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 2, 4'hF, 0);
    vecs[8] = mk("illegal01", 6'b000001, {4'd0,4'd1,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}, 2, 4'hF, 0);
    vecs[9] = mk("fetch_wait",6'b000000, {4'd0,4'd0,4'd0,4'd1,4'd6,4'd7,4'd0,4'd0,4'd0,4'd0}, 6, 4'd0, 2);

    rst_i = 1'b1; Opcode = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    step(1'b0, 6'b000000, 1'b0, 4'd0, "reset_state");

    // Opcode only valid in DECODE; elsewhere it is inverted to prove it is ignored
    for (int v = 0; v < 10; v++) begin
      int w;
      w = vecs[v].waits;
      for (int i = 0; i < vecs[v].len; i++) begin
        logic [3:0] st;
        logic       mr;
        st = vecs[v].seq[i];
        mr = 1'b1;
        if (st == vecs[v].wait_st && w > 0) begin
          mr = 1'b0;
          w--;
        end
        step(1'b0, (st == 4'd1) ? vecs[v].op : ~vecs[v].op, mr, st, vecs[v].name);
      end
    end

    // Reset while a store waits in MEMWR: write still visible, then FETCH
    step(1'b0, 6'b000000, 1'b1, 4'd0, "mid_rst_fetch");
    step(1'b0, 6'b101011, 1'b1, 4'd1, "mid_rst_decode");
    step(1'b0, 6'b100011, 1'b1, 4'd2, "mid_rst_memadr");
    step(1'b0, 6'b100011, 1'b0, 4'd5, "mid_rst_memwr");
    step(1'b1, 6'b100011, 1'b0, 4'd5, "mid_rst_assert");
    step(1'b0, 6'b000000, 1'b0, 4'd0, "mid_rst_after");

    // Reset beats a completing fetch; strobes in that cycle remain visible
    step(1'b1, 6'b000000, 1'b1, 4'd0, "rst_vs_ready");
    step(1'b0, 6'b000000, 1'b0, 4'd0, "rst_vs_ready_after");

    // Back-to-back lw after reset to confirm the latched opcode path again
    step(1'b0, 6'b000000, 1'b1, 4'd0, "lw2_fetch");
    step(1'b0, 6'b100011, 1'b1, 4'd1, "lw2_decode");
    step(1'b0, 6'b101011, 1'b1, 4'd2, "lw2_memadr");
    step(1'b0, 6'b101011, 1'b1, 4'd3, "lw2_memrd");
    step(1'b0, 6'b101011, 1'b0, 4'd4, "lw2_memwb");
    step(1'b0, 6'b000000, 1'b0, 4'd0, "lw2_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
